// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module   : muldiv_unit_if
// Brief    : Request/response bundle between the CPU pipeline and the
//            multiply/divide unit (operation start, HI/LO moves, results).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // CPU side: issues operations and moves, observes results
    modport master (
        output start, op, A, B, mthi, mtlo,
        input  busy, done, hi, lo
    );

    // Unit side
    modport slave (
        input  start, op, A, B, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : 32-bit iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//            Magnitudes are processed unsigned over 32 iterations (shift-add
//            or restoring shift-subtract), then signs are fixed in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit (
    input wire           clk,
    input wire           rst,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [5:0] c_last_iter = 6'd31;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_busy;
    logic        r_done;
    logic [5:0]  r_cnt;
    logic        r_op_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_opd;
    // Multiply: {partial product, remaining multiplier bits}
    // Divide  : {partial remainder, dividend bits / quotient bits}
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_hi_fix;
    logic [31:0] w_lo_fix;

    // Operand magnitudes: op[0]=0 selects the signed variants
    assign w_signed = ~bus.op[0];
    assign w_abs_a  = (w_signed && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    assign w_abs_b  = (w_signed && bus.B[31]) ? (32'd0 - bus.B) : bus.B;

    // One shift-add step: add multiplicand when multiplier LSB is set, shift right
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // One restoring step: shift in next dividend bit, subtract if it fits
    assign w_div_shift = r_acc[63:31];
    assign w_div_diff  = w_div_shift - {1'b0, r_opd};
    assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                        : {w_div_diff[31:0],  r_acc[30:0], 1'b1};

    // Sign correction of the unsigned result; a zero divisor forces LO to all ones
    // while the remainder path already reproduces the dividend in HI
    always_comb begin
        w_prod_fix = r_neg_q ? (64'd0 - r_acc) : r_acc;
        w_hi_fix   = w_prod_fix[63:32];
        w_lo_fix   = w_prod_fix[31:0];
        if (r_op_div) begin
            w_hi_fix = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
            w_lo_fix = r_div0 ? 32'hFFFF_FFFF
                              : (r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_CALC;
            S_CALC:  if (r_cnt == c_last_iter) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register with registered busy and the post-FIX done pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= (r_state == S_FIX);
        end
    end

    // Datapath: operand capture, iteration, result write-back and IDLE moves
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= 6'd0;
            r_op_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_opd    <= 32'd0;
            r_acc    <= 64'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op_div <= bus.op[1];
                        r_opd    <= w_abs_b;
                        r_acc    <= {32'd0, w_abs_a};
                        r_neg_q  <= w_signed & (bus.A[31] ^ bus.B[31]);
                        r_neg_r  <= w_signed & bus.A[31];
                        r_div0   <= (bus.B == 32'd0);
                        r_cnt    <= 6'd0;
                    end else begin
                        if (bus.mthi) r_hi <= bus.A;
                        if (bus.mtlo) r_lo <= bus.A;
                    end
                end
                S_CALC: begin
                    r_acc <= r_op_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX: begin
                    r_hi <= w_hi_fix;
                    r_lo <= w_lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit: directed vector table,
//            hand-written corner sequences and random ops against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_unit_if bus ();

    muldiv_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", what, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    hi = 32'(r);
                    lo = 32'(q);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation (called #1 after an edge in IDLE) and check it fully.
    // with_move raises mthi/mtlo alongside start; inj_cycle (>0) pulses start,
    // moves and fresh operands during that busy cycle.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit with_move, input int inj_cycle);
        logic [31:0] hi0, lo0;
        int          busy_cnt, done_cnt, extra_busy;
        bit          hold_ok;
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.mthi  = with_move;
        bus.mtlo  = with_move;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.op    = 2'($urandom);
        busy_cnt  = 0;
        done_cnt  = 0;
        hold_ok   = 1'b1;
        while (bus.busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.hi !== hi0 || bus.lo !== lo0) hold_ok = 1'b0;
            if (busy_cnt == inj_cycle) begin
                bus.start = 1'b1;
                bus.mthi  = 1'b1;
                bus.mtlo  = 1'b1;
                bus.A     = $urandom;
                bus.B     = $urandom;
            end else begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check({name, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({name, ".hold"}, 64'(hold_ok), 64'd1);
        check({name, ".hi"}, 64'(bus.hi), 64'(exp_hi));
        check({name, ".lo"}, 64'(bus.lo), 64'(exp_lo));
        if (bus.done === 1'b1) done_cnt++;
        extra_busy = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.busy !== 1'b0) extra_busy++;
        end
        check({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, ".no_restart"}, 64'(extra_busy), 64'd0);
        check({name, ".hi_after"}, 64'(bus.hi), 64'(exp_hi));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[11];
        logic [1:0]  rop;
        logic [31:0] ra, rb, rhi, rlo;
        int          cnt, dn, bz;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_DIVU,  32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[5]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
        vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF};

        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 11; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, 1'b0, -1);

        // IDLE moves: both together, then each alone
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.A = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("move_both.hi", 64'(bus.hi), 64'hCAFE_F00D);
        check("move_both.lo", 64'(bus.lo), 64'hCAFE_F00D);
        bus.mthi = 1'b1; bus.A = 32'h1111_2222;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        check("mthi_only.hi", 64'(bus.hi), 64'h1111_2222);
        check("mthi_only.lo", 64'(bus.lo), 64'hCAFE_F00D);
        bus.mtlo = 1'b1; bus.A = 32'h3333_4444;
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        check("mtlo_only.hi", 64'(bus.hi), 64'h1111_2222);
        check("mtlo_only.lo", 64'(bus.lo), 64'h3333_4444);

        // start together with moves: the moves are dropped
        do_op("start_mthi", OP_MULTU, 32'd5, 32'd3, 32'd0, 32'd15, 1'b1, -1);

        // start/mthi/operands pulsed mid-operation are ignored
        do_op("inject", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 10);

        // Reset mid-operation aborts with no result and no done
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.A = 32'h5A5A_0001;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.start = 1'b1; bus.op = OP_MULT; bus.A = 32'd123; bus.B = 32'd456;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 1;
        while (cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("abort.busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        bus.start = 1'b1; bus.mthi = 1'b1; bus.A = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.hi", 64'(bus.hi), 64'd0);
        check("abort.lo", 64'(bus.lo), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        bus.start = 1'b0; bus.mthi = 1'b0;
        dn = 0;
        bz = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) dn++;
            if (bus.busy !== 1'b0) bz++;
        end
        check("abort.no_done", 64'(dn), 64'd0);
        check("abort.no_busy", 64'(bz), 64'd0);
        check("abort.hi_after", 64'(bus.hi), 64'd0);
        bus.mtlo = 1'b1; bus.A = 32'h1234;
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        check("abort.mtlo", 64'(bus.lo), 64'h1234);
        check("abort.mtlo_hi", 64'(bus.hi), 64'd0);

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            ref_model(rop, ra, rb, rhi, rlo);
            do_op($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), rop, ra, rb, rhi, rlo, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
